// File: rtl/elevator_if.sv
// Call inputs and car status outputs of the elevator scheduler, grouped as one bundle.
// The scheduler takes the master side; the call panel and display logic take the slave side.
interface elevator_if #(
  parameter int NUM_FLOORS = 4
);
  logic [NUM_FLOORS-1:0] call_in;
  logic [NUM_FLOORS-1:0] cur_floor;
  logic [NUM_FLOORS-1:0] pending;
  logic                  door_open;
  logic                  moving_up;
  logic                  moving_down;
  logic                  arrive;

  modport master (
    input  call_in,
    output cur_floor, pending, door_open, moving_up, moving_down, arrive
  );

  modport slave (
    output call_in,
    input  cur_floor, pending, door_open, moving_up, moving_down, arrive
  );
endinterface

// File: rtl/elevator_scheduler.sv
// SCAN request scheduler and motion sequencer for a one-hot elevator car.
// Latches calls, times floor moves and door dwell, and drives registered status outputs.
module elevator_scheduler #(
  parameter int NUM_FLOORS = 4,
  parameter int MOVE_TICKS = 25000000,
  parameter int DOOR_TICKS = 50000000
) (
  input logic       clk,
  input logic       rst,
  elevator_if.master bus
);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

  localparam int MAX_TICKS = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
  localparam int CW        = $clog2(MAX_TICKS + 1);
  localparam logic [CW-1:0]         MOVE_LAST = CW'(MOVE_TICKS - 1);
  localparam logic [CW-1:0]         DOOR_LAST = CW'(DOOR_TICKS - 1);
  localparam logic [CW-1:0]         CNT_ONE   = CW'(1);
  localparam logic [NUM_FLOORS-1:0] FLR_ONE   = NUM_FLOORS'(1);

  state_t                state_q, state_d;
  logic [NUM_FLOORS-1:0] cur_floor_q, cur_floor_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic                  dir_up_q, dir_up_d;
  logic [CW-1:0]         move_cnt_q, move_cnt_d;
  logic [CW-1:0]         dwell_cnt_q, dwell_cnt_d;
  logic                  door_open_q, door_open_d;
  logic                  moving_up_q, moving_up_d;
  logic                  moving_down_q, moving_down_d;
  logic                  arrive_q, arrive_d;

  logic [NUM_FLOORS-1:0] clear_mask;
  logic [NUM_FLOORS-1:0] calls_seen;
  logic [NUM_FLOORS-1:0] above_mask;
  logic [NUM_FLOORS-1:0] below_mask;
  logic [NUM_FLOORS-1:0] up_floor;
  logic [NUM_FLOORS-1:0] dn_floor;

  always_comb begin
    state_d     = state_q;
    cur_floor_d = cur_floor_q;
    dir_up_d    = dir_up_q;
    move_cnt_d  = move_cnt_q;
    dwell_cnt_d = dwell_cnt_q;
    clear_mask  = '0;
    arrive_d    = 1'b0;

    calls_seen = pending_q | bus.call_in;
    // Shifting the top floor out yields 0, so 0-1 inverts to an empty above-mask.
    above_mask = ~((cur_floor_q << 1) - FLR_ONE);
    below_mask = cur_floor_q - FLR_ONE;
    up_floor   = cur_floor_q << 1;
    dn_floor   = cur_floor_q >> 1;

    case (state_q)
      IDLE: begin
        if (|(pending_q & cur_floor_q)) begin
          state_d     = DOOR_OPEN;
          clear_mask  = cur_floor_q;
          arrive_d    = 1'b1;
          dwell_cnt_d = '0;
        end else if (|(pending_q & above_mask) && (dir_up_q || ~|(pending_q & below_mask))) begin
          state_d    = MOVE_UP;
          dir_up_d   = 1'b1;
          move_cnt_d = '0;
        end else if (|(pending_q & below_mask)) begin
          state_d    = MOVE_DOWN;
          dir_up_d   = 1'b0;
          move_cnt_d = '0;
        end
      end
      MOVE_UP: begin
        if (move_cnt_q == MOVE_LAST) begin
          move_cnt_d = '0;
          if (~|(calls_seen & above_mask)) begin
            state_d = IDLE;
          end else begin
            cur_floor_d = up_floor;
            if (|(calls_seen & up_floor)) begin
              state_d     = DOOR_OPEN;
              clear_mask  = up_floor;
              arrive_d    = 1'b1;
              dwell_cnt_d = '0;
            end
          end
        end else begin
          move_cnt_d = move_cnt_q + CNT_ONE;
        end
      end
      MOVE_DOWN: begin
        if (move_cnt_q == MOVE_LAST) begin
          move_cnt_d = '0;
          if (~|(calls_seen & below_mask)) begin
            state_d = IDLE;
          end else begin
            cur_floor_d = dn_floor;
            if (|(calls_seen & dn_floor)) begin
              state_d     = DOOR_OPEN;
              clear_mask  = dn_floor;
              arrive_d    = 1'b1;
              dwell_cnt_d = '0;
            end
          end
        end else begin
          move_cnt_d = move_cnt_q + CNT_ONE;
        end
      end
      DOOR_OPEN: begin
        // A call for this floor is absorbed by holding the door rather than latched.
        clear_mask = cur_floor_q;
        if (|(bus.call_in & cur_floor_q)) begin
          dwell_cnt_d = '0;
        end else if (dwell_cnt_q == DOOR_LAST) begin
          state_d     = IDLE;
          dwell_cnt_d = '0;
        end else begin
          dwell_cnt_d = dwell_cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    pending_d     = calls_seen & ~clear_mask;
    door_open_d   = (state_d == DOOR_OPEN);
    moving_up_d   = (state_d == MOVE_UP);
    moving_down_d = (state_d == MOVE_DOWN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cur_floor_q   <= FLR_ONE;
      pending_q     <= '0;
      dir_up_q      <= 1'b1;
      move_cnt_q    <= '0;
      dwell_cnt_q   <= '0;
      door_open_q   <= 1'b0;
      moving_up_q   <= 1'b0;
      moving_down_q <= 1'b0;
      arrive_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_floor_q   <= cur_floor_d;
      pending_q     <= pending_d;
      dir_up_q      <= dir_up_d;
      move_cnt_q    <= move_cnt_d;
      dwell_cnt_q   <= dwell_cnt_d;
      door_open_q   <= door_open_d;
      moving_up_q   <= moving_up_d;
      moving_down_q <= moving_down_d;
      arrive_q      <= arrive_d;
    end
  end

  assign bus.cur_floor   = cur_floor_q;
  assign bus.pending     = pending_q;
  assign bus.door_open   = door_open_q;
  assign bus.moving_up   = moving_up_q;
  assign bus.moving_down = moving_down_q;
  assign bus.arrive      = arrive_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: directed scenarios then random calls/resets,
// every cycle compared against a floor-index/countdown model of the car.
module tb_elevator_scheduler;
  localparam int NF = 4;
  localparam int MT = 4;
  localparam int DT = 3;

  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_DOWN = 2;
  localparam int M_DOOR = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  elevator_if #(.NUM_FLOORS(NF)) bus();

  elevator_scheduler #(
    .NUM_FLOORS(NF),
    .MOVE_TICKS(MT),
    .DOOR_TICKS(DT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int          m_floor;
  logic [NF-1:0] m_pend;
  int          m_mode;
  bit          m_up_pref;
  int          m_timer;
  bit          m_arrive;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic bit any_above(input logic [NF-1:0] p, input int f);
    bit r = 1'b0;
    for (int j = f + 1; j < NF; j++) if (p[j]) r = 1'b1;
    return r;
  endfunction

  function automatic bit any_below(input logic [NF-1:0] p, input int f);
    bit r = 1'b0;
    for (int j = 0; j < f; j++) if (p[j]) r = 1'b1;
    return r;
  endfunction

  // One clock of the car: calls c sampled on this edge.
  task automatic model_step(input bit r, input logic [NF-1:0] c);
    logic [NF-1:0] old;
    bit ab, bl, ahead;
    old = m_pend;
    if (r) begin
      m_floor = 0; m_pend = '0; m_mode = M_IDLE; m_up_pref = 1'b1; m_timer = 0; m_arrive = 1'b0;
      return;
    end
    m_arrive = 1'b0;
    case (m_mode)
      M_IDLE: begin
        ab = any_above(old, m_floor);
        bl = any_below(old, m_floor);
        m_pend = old | c;
        if (old[m_floor]) begin
          m_mode = M_DOOR; m_timer = DT; m_arrive = 1'b1; m_pend[m_floor] = 1'b0;
        end else if (ab && (m_up_pref || !bl)) begin
          m_mode = M_UP; m_up_pref = 1'b1; m_timer = MT;
        end else if (bl) begin
          m_mode = M_DOWN; m_up_pref = 1'b0; m_timer = MT;
        end
      end
      M_UP, M_DOWN: begin
        m_pend = old | c;
        m_timer--;
        if (m_timer == 0) begin
          m_timer = MT;
          ahead = (m_mode == M_UP) ? any_above(m_pend, m_floor) : any_below(m_pend, m_floor);
          if (!ahead) begin
            m_mode = M_IDLE;
          end else begin
            m_floor += (m_mode == M_UP) ? 1 : -1;
            if (m_pend[m_floor]) begin
              m_pend[m_floor] = 1'b0; m_mode = M_DOOR; m_timer = DT; m_arrive = 1'b1;
            end
          end
        end
      end
      default: begin
        m_pend = old | c;
        m_pend[m_floor] = 1'b0;
        if (c[m_floor]) m_timer = DT;
        else begin
          m_timer--;
          if (m_timer == 0) m_mode = M_IDLE;
        end
      end
    endcase
  endtask

  task automatic cycle(input bit r, input logic [NF-1:0] c);
    @(negedge clk);
    rst = r;
    bus.call_in = c;
    @(posedge clk);
    model_step(r, c);
    #1;
    check("cur_floor",   32'(bus.cur_floor),   32'(1 << m_floor));
    check("onehot",      32'($countones(bus.cur_floor)), 32'd1);
    check("pending",     32'(bus.pending),     32'(m_pend));
    check("door_open",   32'(bus.door_open),   32'(m_mode == M_DOOR));
    check("moving_up",   32'(bus.moving_up),   32'(m_mode == M_UP));
    check("moving_down", 32'(bus.moving_down), 32'(m_mode == M_DOWN));
    check("arrive",      32'(bus.arrive),      32'(m_arrive));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0);
  endtask

  task automatic run_to_door(input string tag);
    for (int i = 0; i < 100 && m_mode != M_DOOR; i++) cycle(1'b0, '0);
    check(tag, 32'(bus.door_open), 32'd1);
  endtask

  initial begin
    int hold_left;
    logic [NF-1:0] hold_pat;
    logic [NF-1:0] c;
    bit r;

    bus.call_in = '0;
    m_floor = 0; m_pend = '0; m_mode = M_IDLE; m_up_pref = 1'b1; m_timer = 0; m_arrive = 1'b0;

    cycle(1'b1, '0);
    cycle(1'b1, '0);

    // Single call two floors up, full trip and dwell.
    cycle(1'b0, 4'b0100);
    idle_cycles(25);

    // Up to the top first, then reverse down to floor 0.
    cycle(1'b0, 4'b1001);
    idle_cycles(45);

    // Call for the current floor during dwell holds the door.
    cycle(1'b0, 4'b0010);
    run_to_door("door_reach_a");
    cycle(1'b0, 4'(1 << m_floor));
    idle_cycles(10);

    // Intermediate call picked up on the way up.
    cycle(1'b0, 4'b0001);
    idle_cycles(30);
    cycle(1'b0, 4'b1000);
    idle_cycles(2);
    cycle(1'b0, 4'b0100);
    idle_cycles(40);

    // Reset mid-move, with a call presented during reset.
    cycle(1'b0, 4'b0001);
    for (int i = 0; i < 100 && !(m_mode == M_DOWN && m_floor == 1); i++) cycle(1'b0, '0);
    check("mid_move_down", 32'(bus.moving_down), 32'd1);
    cycle(1'b1, 4'b0100);
    idle_cycles(8);

    // Held call at floor 0 from reset.
    cycle(1'b1, 4'b0001);
    for (int i = 0; i < 8; i++) cycle(1'b0, 4'b0001);
    idle_cycles(10);

    // Random traffic with holds and occasional resets.
    hold_left = 0;
    hold_pat  = '0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 399) == 0);
      if (hold_left > 0) begin
        c = hold_pat;
        hold_left--;
      end else if ($urandom_range(0, 29) == 0) begin
        hold_pat  = NF'($urandom);
        hold_left = $urandom_range(1, 8);
        c = hold_pat;
      end else if ($urandom_range(0, 9) == 0) begin
        c = NF'($urandom);
      end else begin
        c = '0;
      end
      cycle(r, c);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/elevator_scheduler.md
Name: elevator_scheduler

Overview:
- Request scheduler and motion sequencer for the one-hot elevator car.
- Latches floor calls into a pending mask and serves them in SCAN order: keep the current direction while calls remain ahead, then reverse.
- Times floor-to-floor travel and door dwell with internal counters.
- Drives the one-hot current-floor output consumed by the floor display and position logic.

Parameters:
- NUM_FLOORS, 4, number of floors. One-hot width. Must be >= 2.
- MOVE_TICKS, 25000000, clk cycles per one-floor move. Must be >= 1.
- DOOR_TICKS, 50000000, clk cycles the door stays open. Must be >= 1.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- call_in  input  NUM_FLOORS  floor call buttons; bit i = floor i; level or pulse, sampled every cycle.
- cur_floor  output  NUM_FLOORS  one-hot current car position; bit 0 = lowest floor.
- pending  output  NUM_FLOORS  latched, unserved calls.
- door_open  output  1  high while in DOOR_OPEN.
- moving_up  output  1  high in MOVE_UP.
- moving_down  output  1  high in MOVE_DOWN.
- arrive  output  1  one-cycle pulse on the cycle the door opens.

Behaviour:
- Clocking and reset:
  - All outputs are registered.
  - Reset is synchronous, active-high, and wins over every other event, including mid-move and mid-dwell.
  - Reset values: state=IDLE, cur_floor=1 (floor 0), pending=0, dir=UP, both counters=0, all flags 0.
- Pending mask:
  - pending_next = (pending | call_in) & ~clear_mask.
  - A call is visible on pending one cycle after it is sampled.
  - clear_mask = the new cur_floor bit on the DOOR_OPEN entry cycle. On that cycle, clearing takes priority over a simultaneous call for the same floor.
  - While in DOOR_OPEN, a call for cur_floor is not latched and restarts the dwell counter.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN.
- IDLE, evaluated on registered pending, in priority order:
  - Pending bit at cur_floor -> DOOR_OPEN next cycle; arrive=1; clear that bit.
  - Else any pending bit above and (dir=UP or none below) -> MOVE_UP; dir=UP.
  - Else any pending bit below -> MOVE_DOWN; dir=DOWN.
  - Else stay in IDLE.
- MOVE_UP / MOVE_DOWN:
  - move_cnt increments each cycle.
  - When move_cnt = MOVE_TICKS-1: cur_floor shifts left (up) or right (down) by one, and move_cnt returns to 0.
  - Each floor therefore takes exactly MOVE_TICKS cycles.
  - If the new floor's bit is set in pending_next, enter DOOR_OPEN on that same edge: arrive=1 and clear the bit.
  - Otherwise keep moving.
  - The top bit never shifts up and bit 0 never shifts down. Guard: at a boundary with no call ahead, go to IDLE instead of shifting.
- DOOR_OPEN:
  - dwell_cnt counts 0..DOOR_TICKS-1; door_open is high for exactly DOOR_TICKS cycles.
  - Then go to IDLE for one cycle, which re-evaluates with dir preference (SCAN).
- Invariants:
  - cur_floor is always exactly one-hot.
  - moving_up, moving_down and door_open are mutually exclusive.
  - arrive coincides with the first door_open cycle.
- Width rules:
  - Counters are $clog2(max(MOVE_TICKS, DOOR_TICKS)+1) bits and wrap only via explicit reset to 0.
  - Above/below detection uses masks derived from cur_floor: bits above = ~((cur_floor<<1)-1), excluding cur_floor.

Test Plan (bench uses NUM_FLOORS=4, MOVE_TICKS=4, DOOR_TICKS=3):
- Reset, then 1-cycle call_in=0100 -> pending=0100 next cycle; MOVE_UP next; cur_floor 0001->0010->0100 at 4-cycle spacing; arrive pulse and door_open=1 for 3 cycles; pending=0000; then IDLE with all flags 0.
- Car at 0100 in IDLE, dir=UP, call_in=1001 in one cycle -> goes up to 1000 and opens; then reverses: MOVE_DOWN through 0100, 0010 to 0001 and opens; pending=0000 at the end.
- Call at the current floor while DOOR_OPEN, at the 2nd dwell cycle -> pending bit stays 0; door_open total = 1+3 = 4 cycles.
- While at 0001 moving up toward 1000, call_in=0100 arrives before the car reaches 0100 -> stops at 0100 (arrive, 3-cycle dwell), then continues to 1000.
- Assert rst for 1 cycle mid-move at cur_floor=0010 -> next cycle cur_floor=0001, pending=0, IDLE; calls latched during the rst cycle are discarded.
- call_in held at 0001 continuously from reset -> IDLE->DOOR_OPEN; door stays open while held; after release, exactly 3 more dwell cycles, then IDLE; arrive pulses only once.
